// File: rtl/rv_pkg.sv
// Shared RISC-V core constants and types: register-file geometry, the
// writeback entry carried through the long-latency FIFO, and the writeback
// arbiter's starvation-guard states.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic {
        WB_NORMAL = 1'b0,
        WB_FORCE  = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback entries for long-latency results.
// DEPTH must be a power of two so the pointers wrap naturally.
// The caller never pushes when full nor pops when empty.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback-stage arbiter for the single register-file write port.
// Pipeline results win the port with zero latency; long-latency results are
// queued in wb_fifo and drained into free slots. A starvation guard stalls the
// pipeline for one slot after MAX_WAIT consecutive blocked drain cycles.
// Optional macro WB_BYPASS_EN: an accepted long-latency result is written in
// the same cycle when the FIFO is empty and the pipeline leaves the slot free.
module writeback_arbiter
    import rv_pkg::*;
#(
    parameter int XLEN     = rv_pkg::XLEN,  // must match the package width
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_stall,
    input  logic            ll_valid,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
    output logic            ll_ready,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            ll_pending
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_arb_state_e         state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  pipe_stall_q, pipe_stall_d;

    wb_entry_t             fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_push, fifo_pop;

    logic                  pipe_zero, pipe_take, ll_accept, ll_discard, ll_bypass, blocked;

    assign pipe_zero  = (ZERO_REG != 0) && (pipe_rd == 5'd0);
    assign pipe_take  = pipe_valid && !pipe_stall_q && !pipe_zero;
    assign ll_ready   = !fifo_full;
    assign ll_accept  = ll_valid && ll_ready;
    assign ll_discard = (ZERO_REG != 0) && (ll_rd == 5'd0);
    assign fifo_pop   = !pipe_take && !fifo_empty;
`ifdef WB_BYPASS_EN
    assign ll_bypass  = fifo_empty && !pipe_take && ll_accept && !ll_discard;
`else
    assign ll_bypass  = 1'b0;
`endif
    assign fifo_push  = ll_accept && !ll_discard && !ll_bypass;
    assign blocked    = !fifo_empty && pipe_take;
    assign ll_pending = (fifo_count != '0);
    assign pipe_stall = pipe_stall_q;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry ('{rd: ll_rd, data: ll_data}),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Write-port mux: pipeline first, then FIFO head, then optional bypass.
    always_comb begin
        wb_we   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = '0;
        if (pipe_take) begin
            wb_we   = 1'b1;
            wb_rd   = pipe_rd;
            wb_data = pipe_data;
        end else if (!fifo_empty) begin
            wb_we   = 1'b1;
            wb_rd   = fifo_head.rd;
            wb_data = fifo_head.data;
        end else if (ll_bypass) begin
            wb_we   = 1'b1;
            wb_rd   = ll_rd;
            wb_data = ll_data;
        end
        if (!rst_n) begin
            wb_we   = 1'b0;
            wb_rd   = 5'd0;
            wb_data = '0;
        end
    end

    // Starvation guard: count blocked drain cycles, then steal one slot.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pipe_stall_d = 1'b0;
        case (state_q)
            WB_NORMAL: begin
                if (blocked) begin
                    if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                        state_d      = WB_FORCE;
                        wait_cnt_d   = '0;
                        pipe_stall_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            WB_FORCE: begin
                state_d      = WB_NORMAL;
                wait_cnt_d   = '0;
                pipe_stall_d = 1'b0;
            end
            default: begin
                state_d      = WB_NORMAL;
                wait_cnt_d   = '0;
                pipe_stall_d = 1'b0;
            end
        endcase
    end

    // Starvation-guard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WB_NORMAL;
            wait_cnt_q   <= '0;
            pipe_stall_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            pipe_stall_q <= pipe_stall_d;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_writeback_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        stall;
        logic        ready;
        logic        pending;
    } outs_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        ll_valid = 1'b0;
    logic [4:0]  ll_rd = '0;
    logic [31:0] ll_data = '0;

    logic        pipe_stall, ll_ready, wb_we, ll_pending;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        z_stall, z_ready, z_we, z_pending;
    logic [4:0]  z_rd;
    logic [31:0] z_data;

    writeback_arbiter #(.XLEN(32), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ll_pending(ll_pending)
    );

    // Float-file flavour: register 0 is an ordinary destination.
    writeback_arbiter #(.XLEN(32), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .ZERO_REG(0)) u_dut_zr0 (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(z_stall),
        .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(z_ready),
        .wb_we(z_we), .wb_rd(z_rd), .wb_data(z_data), .ll_pending(z_pending)
    );

    always #5 clk = ~clk;

    outs_t dut_o;
    assign dut_o = {wb_we, wb_rd, wb_data, pipe_stall, ll_ready, ll_pending};

    // Literal expectations posted by the stimulus for the next sampling edge.
    logic        lit_en = 1'b0;
    outs_t       lit_exp = '0;
    string       lit_name = "";
    logic        lit_zr0_en = 1'b0;
    logic [37:0] lit_zr0_exp = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    ent_t  mq[$];
    int    run = 0;
    bit    m_stall = 1'b0;
    outs_t e;
    ent_t  h;
    bit    ptake, acc, disc, byp, nonempty;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            run     = 0;
            m_stall = 1'b0;
            e       = '0;
            e.ready = 1'b1;
        end else begin
            nonempty  = (mq.size() != 0);
            e         = '0;
            e.stall   = m_stall;
            e.ready   = (mq.size() != DEPTH);
            e.pending = nonempty;
            ptake     = pipe_valid && !m_stall && (pipe_rd != 5'd0);
            acc       = ll_valid && e.ready;
            disc      = (ll_rd == 5'd0);
            byp       = 1'b0;
            if (ptake) begin
                e.we = 1'b1; e.rd = pipe_rd; e.data = pipe_data;
            end else if (nonempty) begin
                h = mq.pop_front();
                e.we = 1'b1; e.rd = h.rd; e.data = h.data;
            end else if (BYP && acc && !disc) begin
                byp = 1'b1;
                e.we = 1'b1; e.rd = ll_rd; e.data = ll_data;
            end
            if (acc && !disc && !byp) mq.push_back({ll_rd, ll_data});
            if (m_stall) begin
                m_stall = 1'b0;
                run     = 0;
            end else if (nonempty && ptake) begin
                run = run + 1;
                if (run == MAX_WAIT) begin
                    m_stall = 1'b1;
                    run     = 0;
                end
            end else begin
                run = 0;
            end
        end
        n_cmp++;
        if (dut_o !== e) begin
            n_bad++;
            $display("FAIL model t=%0t actual=%h required=%h", $time, dut_o, e);
        end
        if (lit_en) begin
            n_cmp++;
            if (dut_o !== lit_exp) begin
                n_bad++;
                $display("FAIL %s t=%0t actual=%h required=%h", lit_name, $time, dut_o, lit_exp);
            end
        end
        if (lit_zr0_en) begin
            n_cmp++;
            if ({z_we, z_rd, z_data} !== lit_zr0_exp) begin
                n_bad++;
                $display("FAIL zr0_write t=%0t actual=%h required=%h", $time, {z_we, z_rd, z_data}, lit_zr0_exp);
            end
        end
    end

    function automatic outs_t o(input logic we, input logic [4:0] rd, input logic [31:0] d,
                                input logic st, input logic rdy, input logic pend);
        return {we, rd, d, st, rdy, pend};
    endfunction

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        @(posedge clk);
        #1;
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        ll_valid = lv; ll_rd = lrd; ll_data = ld;
        lit_en = 1'b0;
        lit_zr0_en = 1'b0;
    endtask

    task automatic expect_o(input string nm, input outs_t ex);
        lit_name = nm;
        lit_exp  = ex;
        lit_en   = 1'b1;
    endtask

    initial begin
        expect_o("reset_state", o(0, 0, 0, 0, 1, 0));
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        lit_en = 1'b0;

        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        expect_o("pipe_only", o(1, 5, 32'hDEADBEEF, 0, 1, 0));
        drive(1, 3, 32'h33, 1, 7, 32'h11);
        expect_o("collision_pipe", o(1, 3, 32'h33, 0, 1, 0));
        drive(0, 0, 0, 0, 0, 0);
        expect_o("collision_drain", o(1, 7, 32'h11, 0, 1, 1));

        drive(0, 0, 0, 1, 9, 32'h99);
        expect_o("idle_ll_t0", BYP ? o(1, 9, 32'h99, 0, 1, 0) : o(0, 0, 0, 0, 1, 0));
        drive(0, 0, 0, 0, 0, 0);
        expect_o("idle_ll_t1", BYP ? o(0, 0, 0, 0, 1, 0) : o(1, 9, 32'h99, 0, 1, 1));

        drive(1, 0, 32'hAA, 1, 9, 32'h55);
        expect_o("x0_t0", BYP ? o(1, 9, 32'h55, 0, 1, 0) : o(0, 0, 0, 0, 1, 0));
        lit_zr0_exp = {1'b1, 5'd0, 32'hAA};
        lit_zr0_en  = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        expect_o("x0_t1", BYP ? o(0, 0, 0, 0, 1, 0) : o(1, 9, 32'h55, 0, 1, 1));

        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h100 + i, 1, 5'(10 + i), i);
            expect_o("fill", o(1, 1, 32'h100 + i, 0, 1, i != 0));
        end
        drive(1, 1, 32'h104, 1, 20, 32'h20);
        expect_o("full_ready", o(1, 1, 32'h104, 0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            expect_o("full_drain", o(1, 5'(10 + i), i, 0, i != 0, 1));
        end

        drive(1, 2, 32'h200, 1, 15, 32'hF0);
        expect_o("starve_push", o(1, 2, 32'h200, 0, 1, 0));
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive(1, 2, 32'h200, 0, 0, 0);
            expect_o("starve_blocked", o(1, 2, 32'h200, 0, 1, 1));
        end
        drive(1, 2, 32'h200, 0, 0, 0);
        expect_o("starve_force", o(1, 15, 32'hF0, 1, 1, 1));
        drive(1, 2, 32'h200, 0, 0, 0);
        expect_o("starve_release", o(1, 2, 32'h200, 0, 1, 0));

        drive(1, 2, 32'h200, 1, 21, 32'h21);
        expect_o("rst_fill0", o(1, 2, 32'h200, 0, 1, 0));
        drive(1, 2, 32'h200, 1, 22, 32'h22);
        expect_o("rst_fill1", o(1, 2, 32'h200, 0, 1, 1));
        drive(1, 2, 32'h200, 0, 0, 0);
        rst_n = 1'b0;
        expect_o("in_reset", o(0, 0, 0, 0, 1, 0));
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        expect_o("after_reset", o(0, 0, 0, 0, 1, 0));

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            lit_en     = 1'b0;
            lit_zr0_en = 1'b0;
            rst_n      = ($urandom_range(0, 299) != 0);
            pipe_valid = (c < 1500) ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 40);
            pipe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pipe_data  = $urandom;
            ll_valid   = ($urandom_range(0, 1) == 1);
            ll_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ll_data    = $urandom;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
